// File: rtl/i2c_poll_pkg.sv
// Shared constants for the I2C sensor poller: FSM state codes, the fixed
// read direction bit and the sizing limits for devices and bytes per read.
package i2c_poll_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  localparam logic I2C_RD = 1'b1;

  localparam int unsigned MAX_DEV    = 8;
  localparam int unsigned MAX_BYTES  = 4;
  localparam int unsigned DEV_IDX_W  = $clog2(MAX_DEV);
  localparam int unsigned BYTE_CNT_W = $clog2(MAX_BYTES + 1);

endpackage

// File: rtl/poll_tick_gen.sv
// Poll-round prescaler: counts 0..POLL_DIV-1 while enabled and pulses tick
// on the wrap cycle. The count holds while disabled.
module poll_tick_gen #(
  parameter int unsigned POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(POLL_DIV);
  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, advancing only while enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_sensor_poller.sv
// Periodic multi-device I2C read sequencer. Polls NUM_DEV addresses
// round-robin through an i2c_master ena/busy/data_rd handshake and keeps one
// result register per device.
// Optional build macro I2C_TIMEOUT_EN adds a busy-phase watchdog (TIMEOUT_CYC).
module i2c_sensor_poller
  import i2c_poll_pkg::*;
#(
  parameter int unsigned             NUM_DEV      = 1,
  parameter int unsigned             BYTES_PER_RD = 2,
  parameter int unsigned             POLL_DIV     = 50000,
  parameter logic [NUM_DEV*7-1:0]    DEV_ADDRS    = {NUM_DEV{7'h4B}},
  parameter int unsigned             TIMEOUT_CYC  = 65535
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               poll_en,
  output logic                               i2c_ena,
  output logic [6:0]                         i2c_addr,
  output logic                               i2c_rw,
  input  logic                               i2c_busy,
  input  logic [7:0]                         i2c_data_rd,
  input  logic                               i2c_ack_err,
  output logic [NUM_DEV*BYTES_PER_RD*8-1:0]  rd_data,
  output logic [NUM_DEV-1:0]                 rd_valid,
  output logic [NUM_DEV-1:0]                 rd_err,
  output logic                               round_done
);

  localparam int unsigned           RW        = BYTES_PER_RD * 8;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_RD);
  localparam logic [DEV_IDX_W-1:0]  LAST_DEV  = DEV_IDX_W'(NUM_DEV - 1);

  logic [2:0]            state;
  logic [DEV_IDX_W-1:0]  dev;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [RW-1:0]         shadow;
  logic                  xfer_err;
  logic                  busy_q;
  logic                  busy_rise;
  logic                  busy_fall;
  logic                  tick;
  logic                  wd_expired;
  logic [6:0]            cur_addr;

  poll_tick_gen #(.POLL_DIV(POLL_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (poll_en),
    .tick  (tick)
  );

  assign i2c_rw    = I2C_RD;
  assign busy_rise = i2c_busy & ~busy_q;
  assign busy_fall = ~i2c_busy & busy_q;

  // Address of the currently selected device
  always_comb begin
    cur_addr = DEV_ADDRS[6:0];
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      if (dev == DEV_IDX_W'(k)) cur_addr = DEV_ADDRS[k*7 +: 7];
    end
  end

  // Busy delayed one cycle for edge detection
  always_ff @(posedge clk) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= i2c_busy;
  end

`ifdef I2C_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Watchdog: counts XFER cycles, restarted by every busy edge
  always_ff @(posedge clk) begin
    if (reset || state != ST_XFER || busy_rise || busy_fall) wd_cnt <= '0;
    else                                                     wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_expired = (state == ST_XFER) && !busy_rise && !busy_fall &&
                      (wd_cnt == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign wd_expired     = 1'b0;
`endif

  // Sequencer FSM, shadow shift register and per-device result bank
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dev        <= '0;
      byte_cnt   <= '0;
      shadow     <= '0;
      xfer_err   <= 1'b0;
      i2c_ena    <= 1'b0;
      i2c_addr   <= DEV_ADDRS[6:0];
      rd_data    <= '0;
      rd_valid   <= '0;
      rd_err     <= '0;
      round_done <= 1'b0;
    end else begin
      rd_valid   <= '0;
      round_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick && poll_en) begin
            dev   <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          i2c_addr <= cur_addr;
          i2c_ena  <= 1'b1;
          byte_cnt <= '0;
          xfer_err <= 1'b0;
          state    <= ST_XFER;
        end
        ST_XFER: begin
          xfer_err <= xfer_err | i2c_ack_err;
          if (wd_expired) begin
            i2c_ena <= 1'b0;
            for (int unsigned k = 0; k < NUM_DEV; k++) begin
              if (dev == DEV_IDX_W'(k)) rd_err[k] <= 1'b1;
            end
            state <= ST_NEXT;
          end else begin
            // ena must fall on the rise of the last byte so the master stops after it
            if (busy_rise) begin
              byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
              if (byte_cnt + BYTE_CNT_W'(1) == LAST_BYTE) i2c_ena <= 1'b0;
            end
            if (busy_fall) begin
              shadow <= RW'({shadow, i2c_data_rd});
              if (byte_cnt == LAST_BYTE) state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          for (int unsigned k = 0; k < NUM_DEV; k++) begin
            if (dev == DEV_IDX_W'(k)) begin
              if (xfer_err) begin
                rd_err[k] <= 1'b1;
              end else begin
                rd_data[k*RW +: RW] <= shadow;
                rd_err[k]           <= 1'b0;
                rd_valid[k]         <= 1'b1;
              end
            end
          end
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (dev == LAST_DEV) begin
            round_done <= 1'b1;
            dev        <= '0;
            state      <= ST_IDLE;
          end else if (poll_en) begin
            dev   <= dev + DEV_IDX_W'(1);
            state <= ST_START;
          end else begin
            dev   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Directed bench for i2c_sensor_poller: three devices (4B/48/49), two bytes
// per read, short poll period, with a behavioural i2c_master model.
module tb_i2c_sensor_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        poll_en;
  logic        i2c_ena;
  logic [6:0]  i2c_addr;
  logic        i2c_rw;
  logic        i2c_busy;
  logic [7:0]  i2c_data_rd;
  logic        i2c_ack_err;
  logic [47:0] rd_data;
  logic [2:0]  rd_valid;
  logic [2:0]  rd_err;
  logic        round_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_sensor_poller #(
    .NUM_DEV      (3),
    .BYTES_PER_RD (2),
    .POLL_DIV     (40),
    .DEV_ADDRS    ({7'h49, 7'h48, 7'h4B}),
    .TIMEOUT_CYC  (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .poll_en     (poll_en),
    .i2c_ena     (i2c_ena),
    .i2c_addr    (i2c_addr),
    .i2c_rw      (i2c_rw),
    .i2c_busy    (i2c_busy),
    .i2c_data_rd (i2c_data_rd),
    .i2c_ack_err (i2c_ack_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .round_done  (round_done)
  );

  // Master model data: first and second byte returned per device
  logic [7:0] dev_b0 [3];
  logic [7:0] dev_b1 [3];
  logic [6:0] nack_addr = 7'h00;
  logic       stuck     = 1'b0;

  function automatic int addr_idx(input logic [6:0] a);
    if (a == 7'h48) return 1;
    if (a == 7'h49) return 2;
    return 0;
  endfunction

  // Behavioural i2c_master: one busy pulse per byte while ena stays high
  initial begin
    int nb;
    int idx;
    logic [6:0] a;
    i2c_busy    = 1'b0;
    i2c_data_rd = 8'h00;
    i2c_ack_err = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_ena) begin
        nb  = 0;
        a   = i2c_addr;
        idx = addr_idx(a);
        do begin
          repeat (2) @(negedge clk);
          i2c_busy    = 1'b1;
          i2c_ack_err = (a == nack_addr);
          repeat (5) @(negedge clk);
          while (stuck) @(negedge clk);
          i2c_data_rd = (nb == 0) ? dev_b0[idx] : dev_b1[idx];
          i2c_busy    = 1'b0;
          nb++;
          repeat (2) @(negedge clk);
        end while (i2c_ena && nb < 4);
        i2c_ack_err = 1'b0;
      end
    end
  end

  // Event log sampled just after each rising edge
  int         cyc = 0;
  logic       ena_p = 1'b0;
  logic       busy_p = 1'b0;
  logic [6:0] addr_q[$];
  logic       rise_ena_q[$];
  int         valid_q[$];
  int         lat_q[$];
  int         round_cnt = 0;
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  int         ena_fall_cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (i2c_ena && !ena_p) addr_q.push_back(i2c_addr);
      if (!i2c_ena && ena_p) ena_fall_cyc = cyc;
      if (i2c_busy && !busy_p) begin
        rise_ena_q.push_back(i2c_ena);
        rise_cyc = cyc;
      end
      if (!i2c_busy && busy_p) fall_cyc = cyc;
      for (int k = 0; k < 3; k++) begin
        if (rd_valid[k]) begin
          valid_q.push_back(k);
          lat_q.push_back(cyc - fall_cyc);
        end
      end
      if (round_done) round_cnt++;
      ena_p  = i2c_ena;
      busy_p = i2c_busy;
    end
  end

  task automatic clear_logs();
    addr_q.delete();
    rise_ena_q.delete();
    valid_q.delete();
    lat_q.delete();
  endtask

  // which: 0 = ena high, 1 = busy high, 2 = ena low, 3 = round_done seen
  task automatic wait_for(input int which, input int budget, input int start_rounds,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if ((which == 0 && i2c_ena) || (which == 1 && i2c_busy) ||
          (which == 2 && !i2c_ena) || (which == 3 && round_cnt > start_rounds)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [20:0] pack_addr();
    logic [20:0] v = '1;
    for (int i = 0; i < addr_q.size() && i < 3; i++) v[20-7*i -: 7] = addr_q[i];
    return v;
  endfunction

  function automatic logic [11:0] pack_valid();
    logic [11:0] v = '1;
    for (int i = 0; i < valid_q.size() && i < 3; i++) v[11-4*i -: 4] = 4'(valid_q[i]);
    return v;
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    poll_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (i2c_ena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b want 0", i2c_ena); end
    checks++; if (i2c_addr !== 7'h4B) begin errors++; $display("FAIL reset_addr: got %h want 4b", i2c_addr); end
    checks++; if (rd_data !== 48'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL reset_rd_valid: got %b want 000", rd_valid); end
    checks++; if (rd_err !== 3'b000) begin errors++; $display("FAIL reset_rd_err: got %b want 000", rd_err); end
    checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL reset_round_done: got %b want 0", round_done); end
    checks++; if (i2c_rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b want 1", i2c_rw); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_round();
    bit ok;
    int start;
    int bad;
    logic [5:0] rises;
    dev_b0[0] = 8'h0C; dev_b1[0] = 8'h80;
    dev_b0[1] = 8'h12; dev_b1[1] = 8'h34;
    dev_b0[2] = 8'hAB; dev_b1[2] = 8'hCD;
    clear_logs();
    start   = round_cnt;
    poll_en = 1'b1;
    wait_for(3, 600, start, ok);
    poll_en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL round_wait: got timeout want round_done"); end
    checks++; if (addr_q.size() != 3 || pack_addr() !== {7'h4B, 7'h48, 7'h49}) begin
      errors++; $display("FAIL round_addr_seq: got n=%0d %h want n=3 %h", addr_q.size(), pack_addr(), {7'h4B, 7'h48, 7'h49}); end
    checks++; if (valid_q.size() != 3 || pack_valid() !== 12'h012) begin
      errors++; $display("FAIL round_valid_order: got n=%0d %h want n=3 012", valid_q.size(), pack_valid()); end
    checks++; if (round_cnt - start != 1) begin errors++; $display("FAIL round_done_count: got %0d want 1", round_cnt - start); end
    checks++; if (rd_data !== 48'hABCD_1234_0C80) begin errors++; $display("FAIL round_rd_data: got %h want abcd12340c80", rd_data); end
    checks++; if (rd_err !== 3'b000) begin errors++; $display("FAIL round_rd_err: got %b want 000", rd_err); end
    rises = '1;
    for (int i = 0; i < rise_ena_q.size() && i < 6; i++) rises[5-i] = rise_ena_q[i];
    checks++; if (rise_ena_q.size() != 6 || rises !== 6'b101010) begin
      errors++; $display("FAIL round_ena_at_rise: got n=%0d %b want n=6 101010", rise_ena_q.size(), rises); end
    // busy falls half a cycle before the edge that first sees it; rd_valid follows one edge later
    bad = 0;
    foreach (lat_q[i]) if (lat_q[i] != 1) bad++;
    checks++; if (lat_q.size() != 3 || bad != 0) begin
      errors++; $display("FAIL round_valid_latency: got n=%0d bad=%0d want n=3 bad=0", lat_q.size(), bad); end
    checks++; if (i2c_ena !== 1'b0) begin errors++; $display("FAIL round_ena_idle: got %b want 0", i2c_ena); end
  endtask

  task automatic test_nack();
    bit ok;
    int start;
    dev_b0[0] = 8'h11; dev_b1[0] = 8'h11;
    dev_b0[1] = 8'h55; dev_b1[1] = 8'h55;
    dev_b0[2] = 8'h22; dev_b1[2] = 8'h33;
    nack_addr = 7'h48;
    clear_logs();
    start   = round_cnt;
    poll_en = 1'b1;
    wait_for(3, 600, start, ok);
    poll_en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nack_wait: got timeout want round_done"); end
    checks++; if (rd_err !== 3'b010) begin errors++; $display("FAIL nack_rd_err: got %b want 010", rd_err); end
    checks++; if (rd_data !== 48'h2233_1234_1111) begin errors++; $display("FAIL nack_rd_data: got %h want 223312341111", rd_data); end
    checks++; if (valid_q.size() != 2 || pack_valid() !== 12'h02F) begin
      errors++; $display("FAIL nack_valid_order: got n=%0d %h want n=2 02f", valid_q.size(), pack_valid()); end
    nack_addr = 7'h00;
    clear_logs();
    start   = round_cnt;
    poll_en = 1'b1;
    wait_for(3, 600, start, ok);
    poll_en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nack_clear_wait: got timeout want round_done"); end
    checks++; if (rd_err !== 3'b000) begin errors++; $display("FAIL nack_clear_rd_err: got %b want 000", rd_err); end
    checks++; if (rd_data !== 48'h2233_5555_1111) begin errors++; $display("FAIL nack_clear_rd_data: got %h want 223355551111", rd_data); end
    checks++; if (valid_q.size() != 3 || pack_valid() !== 12'h012) begin
      errors++; $display("FAIL nack_clear_valid: got n=%0d %h want n=3 012", valid_q.size(), pack_valid()); end
  endtask

  task automatic test_poll_en_drop();
    bit ok_ena;
    bit ok_busy;
    int start;
    dev_b0[0] = 8'h77; dev_b1[0] = 8'h88;
    clear_logs();
    start   = round_cnt;
    poll_en = 1'b1;
    wait_for(0, 100, 0, ok_ena);
    wait_for(1, 20, 0, ok_busy);
    poll_en = 1'b0;
    repeat (150) @(posedge clk);
    #2;
    checks++; if (ok_ena !== 1'b1 || ok_busy !== 1'b1) begin
      errors++; $display("FAIL drop_wait: got ena=%b busy=%b want 1 1", ok_ena, ok_busy); end
    checks++; if (addr_q.size() != 1 || addr_q[0] !== 7'h4B) begin
      errors++; $display("FAIL drop_starts: got n=%0d want n=1 addr 4b", addr_q.size()); end
    checks++; if (valid_q.size() != 1 || pack_valid() !== 12'h0FF) begin
      errors++; $display("FAIL drop_valid: got n=%0d %h want n=1 0ff", valid_q.size(), pack_valid()); end
    checks++; if (round_cnt != start) begin errors++; $display("FAIL drop_round_done: got %0d want 0", round_cnt - start); end
    checks++; if (rd_data !== 48'h2233_5555_7788) begin errors++; $display("FAIL drop_rd_data: got %h want 223355557788", rd_data); end
    checks++; if (i2c_ena !== 1'b0) begin errors++; $display("FAIL drop_ena_idle: got %b want 0", i2c_ena); end
  endtask

  task automatic test_reset_mid();
    bit ok_ena;
    bit ok_busy;
    bit ok;
    int start;
    clear_logs();
    poll_en = 1'b1;
    wait_for(0, 100, 0, ok_ena);
    wait_for(1, 20, 0, ok_busy);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    checks++; if (ok_ena !== 1'b1 || ok_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_wait: got ena=%b busy=%b want 1 1", ok_ena, ok_busy); end
    checks++; if (i2c_ena !== 1'b0) begin errors++; $display("FAIL rstmid_ena: got %b want 0", i2c_ena); end
    checks++; if (rd_data !== 48'h0) begin errors++; $display("FAIL rstmid_rd_data: got %h want 0", rd_data); end
    checks++; if (i2c_addr !== 7'h4B) begin errors++; $display("FAIL rstmid_addr: got %h want 4b", i2c_addr); end
    clear_logs();
    start = round_cnt;
    wait_for(3, 600, start, ok);
    poll_en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_round_wait: got timeout want round_done"); end
    checks++; if (addr_q.size() != 3 || pack_addr() !== {7'h4B, 7'h48, 7'h49}) begin
      errors++; $display("FAIL rstmid_addr_seq: got n=%0d %h want n=3 %h", addr_q.size(), pack_addr(), {7'h4B, 7'h48, 7'h49}); end
    checks++; if (rd_data !== 48'h2233_5555_7788) begin errors++; $display("FAIL rstmid_rd_data_after: got %h want 223355557788", rd_data); end
  endtask

`ifdef I2C_TIMEOUT_EN
  task automatic test_timeout();
    bit ok_ena;
    bit ok_low;
    clear_logs();
    stuck   = 1'b1;
    poll_en = 1'b1;
    wait_for(0, 100, 0, ok_ena);
    wait_for(2, 300, 0, ok_low);
    poll_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (ok_ena !== 1'b1 || ok_low !== 1'b1) begin
      errors++; $display("FAIL timeout_wait: got ena=%b low=%b want 1 1", ok_ena, ok_low); end
    checks++; if (ena_fall_cyc - rise_cyc != 100) begin
      errors++; $display("FAIL timeout_cycles: got %0d want 100", ena_fall_cyc - rise_cyc); end
    checks++; if (rd_err !== 3'b001) begin errors++; $display("FAIL timeout_rd_err: got %b want 001", rd_err); end
    checks++; if (valid_q.size() != 0) begin errors++; $display("FAIL timeout_no_valid: got %0d pulses want 0", valid_q.size()); end
    stuck = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    checks++; if (addr_q.size() != 1 || i2c_ena !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got starts=%0d ena=%b want 1 0", addr_q.size(), i2c_ena); end
    checks++; if (rd_data !== 48'h2233_5555_7788) begin errors++; $display("FAIL timeout_rd_data: got %h want 223355557788", rd_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_round();
    test_nack();
    test_poll_en_drop();
    test_reset_mid();
`ifdef I2C_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
